// File: rtl/cla_nibble_serial_adder.sv
// cla_nibble_serial_adder: WIDTH-bit adder that reuses one 4-bit CLA, one nibble per clock, LSB first
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake for a, b, cin
//   out_valid/out_ready : result handshake for sum, cout, overflow (held stable while stalled)
module carry_lookahead_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       gg,
  output logic       pg
);
  logic [3:0] g, p, c;
  assign g = a & b;
  assign p = a ^ b;
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign s  = p ^ c;
  assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign pg = &p;
endmodule

module cla_nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int NIB = WIDTH / 4;
  localparam int CW  = NIB > 1 ? $clog2(NIB) : 1;
  if (WIDTH % 4 != 0 || WIDTH < 4) begin : g_width_check
    $error("WIDTH must be a multiple of 4 and >= 4");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t          state;
  logic [WIDTH-1:0] a_r, b_r, acc, acc_nxt;
  logic [CW-1:0]    cnt;
  logic             c, c_nxt, gg, pg, last;
  logic [3:0]       s;
  carry_lookahead_4bit u_cla (
    .a (a_r[4*cnt +: 4]),
    .b (b_r[4*cnt +: 4]),
    .ci(c),
    .s (s),
    .gg(gg),
    .pg(pg)
  );
  assign c_nxt = gg | (pg & c);
  assign last  = cnt == CW'(NIB - 1);
  // acc_nxt carries the nibble being written this cycle so the final copy into sum is complete
  always_comb begin
    acc_nxt = acc;
    acc_nxt[4*cnt +: 4] = s;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      cnt       <= '0;
      c         <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      acc       <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r      <= a;
          b_r      <= b;
          c        <= cin;
          cnt      <= '0;
          in_ready <= 1'b0;
          state    <= RUN;
        end
        RUN: begin
          acc <= acc_nxt;
          c   <= c_nxt;
          cnt <= cnt + CW'(1);
          if (last) begin
            state     <= DONE;
            out_valid <= 1'b1;
            sum       <= acc_nxt;
            cout      <= c_nxt;
            overflow  <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (acc_nxt[WIDTH-1] != a_r[WIDTH-1]);
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// tb_cla_nibble_serial_adder: scoreboard bench for WIDTH=16 and WIDTH=4 instances
module tb_cla_nibble_serial_adder;
  logic clk = 0, rst = 1;
  logic iv16 = 0, ir16, ci16 = 0, ov16, or16 = 0, co16, vf16;
  logic [15:0] a16 = 0, b16 = 0, s16;
  logic iv4 = 0, ir4, ci4 = 0, ov4, or4 = 0, co4, vf4;
  logic [3:0] a4 = 0, b4 = 0, s4;
  logic rnd = 0;
  int vectors = 0, errs = 0;
  logic [17:0] q16[$];
  logic [5:0]  q4[$];

  always #5 clk = ~clk;

  cla_nibble_serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .cin(ci16),
    .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(co16), .overflow(vf16));
  cla_nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .cin(ci4),
    .out_valid(ov4), .out_ready(or4), .sum(s4), .cout(co4), .overflow(vf4));

  function automatic logic [17:0] m16(input logic [15:0] x, y, input logic c);
    logic [16:0] t;
    t = {1'b0, x} + {1'b0, y} + 17'(c);
    return {t[16], t[15:0], (x[15] == y[15]) && (t[15] != x[15])};
  endfunction

  function automatic logic [5:0] m4(input logic [3:0] x, y, input logic c);
    logic [4:0] t;
    t = {1'b0, x} + {1'b0, y} + 5'(c);
    return {t[4], t[3:0], (x[3] == y[3]) && (t[3] != x[3])};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && iv16 && ir16) q16.push_back(m16(a16, b16, ci16));
    if (!rst && iv4 && ir4) q4.push_back(m4(a4, b4, ci4));
    if (!rst && ov16 && or16) begin
      if (q16.size() == 0) chk("sb16_unexpected", 1, 0);
      else chk("sb16", {14'd0, co16, s16, vf16}, {14'd0, q16.pop_front()});
    end
    if (!rst && ov4 && or4) begin
      if (q4.size() == 0) chk("sb4_unexpected", 1, 0);
      else chk("sb4", {26'd0, co4, s4, vf4}, {26'd0, q4.pop_front()});
    end
  end

  always @(posedge clk) if (rnd) begin
    #1 or16 = 1'($urandom_range(0, 1));
  end

  task automatic send16(input logic [15:0] x, y, input logic c);
    a16 = x; b16 = y; ci16 = c; iv16 = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ir16) begin
        @(posedge clk); #1;
        iv16 = 0; a16 = 16'($urandom); b16 = 16'($urandom); ci16 = 1'($urandom);
        return;
      end
    end
    chk("send16_timeout", 0, 1);
    iv16 = 0;
  endtask

  task automatic send4(input logic [3:0] x, y, input logic c);
    a4 = x; b4 = y; ci4 = c; iv4 = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ir4) begin
        @(posedge clk); #1;
        iv4 = 0;
        return;
      end
    end
    chk("send4_timeout", 0, 1);
    iv4 = 0;
  endtask

  task automatic wait_ov16(output int n);
    n = 0;
    while (!ov16 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run16(input string tag, input logic [15:0] x, y, input logic c);
    int n;
    logic [17:0] e;
    e = m16(x, y, c);
    send16(x, y, c);
    wait_ov16(n);
    chk({tag, "_latency"}, n, 4);
    chk({tag, "_sum"}, s16, e[16:1]);
    chk({tag, "_cout"}, co16, e[17]);
    chk({tag, "_ovf"}, vf16, e[0]);
    or16 = 1;
    @(posedge clk); #1;
    or16 = 0;
    chk({tag, "_idle"}, {ov16, ir16}, 2'b01);
  endtask

  initial begin
    int n;
    logic [15:0] held;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_state16", {ov16, ir16, co16, vf16, s16}, {4'b0100, 16'h0});
    chk("rst_state4", {ov4, ir4, co4, vf4, s4}, {4'b0100, 4'h0});
    run16("t1", 16'h1234, 16'h4321, 0);
    run16("t2a", 16'hFFFF, 16'h0001, 0);
    run16("t2b", 16'h7FFF, 16'h0001, 0);
    run16("t3", 16'hFFFF, 16'hFFFF, 1);
    run16("neg", 16'h8000, 16'h8000, 0);
    send16(16'hA5A5, 16'h1111, 1);
    wait_ov16(n);
    held = s16;
    chk("bp_sum", s16, 16'hB6B7);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_hold", {ov16, ir16, co16, vf16, s16}, {4'b1000, held});
    end
    or16 = 1;
    @(posedge clk); #1;
    or16 = 0;
    chk("bp_release", {ov16, ir16}, 2'b01);
    send16(16'h5555, 16'h1111, 0);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    q16.delete();
    chk("rst_run", {ov16, ir16, s16}, {2'b01, 16'h0});
    run16("t5", 16'h0001, 16'h0002, 0);
    or4 = 1;
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int c = 0; c < 2; c++)
          send4(4'(x), 4'(y), 1'(c));
    rnd = 1;
    for (int i = 0; i < 3000; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1 send16(16'($urandom), 16'($urandom), 1'($urandom));
    end
    rnd = 0;
    #1 or16 = 1;
    for (int i = 0; i < 50 && (q16.size() != 0 || q4.size() != 0); i++) @(posedge clk);
    @(negedge clk);
    chk("drain16", q16.size(), 0);
    chk("drain4", q4.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
